sparc_ifu_instq: RTL and testbench

SPARC_IFU_INSTQ -- requirements
Module: sparc_ifu_instq

---
 rtl/sparc_ifu_instq_pkg.sv | 13 +
 rtl/sparc_ifu_instq_ctl.sv | 78 +++++++
 rtl/sparc_ifu_instq.sv | 69 ++++++
 tb/tb_sparc_ifu_instq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sparc_ifu_instq_pkg.sv
// Shared IFU instruction-queue definitions: default depth, SPARC nop word
// and pointer width derivation.
package sparc_ifu_instq_pkg;

    localparam int          INSTQ_DEPTH_DEF = 4;
    localparam logic [31:0] INSTQ_NOP_INST  = 32'h0100_0000;

    // Pointer width for a power-of-two depth; depth 2 still needs one bit.
    function automatic int instq_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sparc_ifu_instq_ctl.sv
// Instruction queue control: read/write pointers, occupancy count,
// full flag and sticky overflow error. Flush clears pointers and count.
module sparc_ifu_instq_ctl
    import sparc_ifu_instq_pkg::*;
#(
    parameter  int DEPTH = INSTQ_DEPTH_DEF,
    localparam int PW    = instq_ptr_w(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          rclk,
    input  logic          arst,
    input  logic          se,
    input  logic          ifq_inst_vld_f,
    input  logic          dtu_stall_s,
    input  logic          fcl_flush_s,
    output logic          o_push,
    output logic [PW-1:0] o_wr_ptr,
    output logic [PW-1:0] o_rd_ptr,
    output logic [CW-1:0] o_cnt,
    output logic          o_vld,
    output logic          o_full,
    output logic          o_ovf_err
);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_ovf_err;

    logic          w_full;
    logic          w_vld;
    logic          w_push;
    logic          w_pop;
    logic          w_unused_se;

    // Scan enable has no functional role in this behavioural flop model.
    assign w_unused_se = se;

    assign w_full = (r_cnt == CW'(DEPTH));
    assign w_vld  = (r_cnt != '0);
    assign w_push = ifq_inst_vld_f & ~w_full & ~fcl_flush_s;
    assign w_pop  = w_vld & ~dtu_stall_s & ~fcl_flush_s;

    // Pointer and count update; flush wins over push and pop.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (fcl_flush_s) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // Sticky overflow: any push attempt while full, cleared only by reset.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            r_ovf_err <= 1'b0;
        end else if (ifq_inst_vld_f & w_full) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign o_push    = w_push;
    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_cnt     = r_cnt;
    assign o_vld     = w_vld;
    assign o_full    = w_full;
    assign o_ovf_err = r_ovf_err;

endmodule

// File: rtl/sparc_ifu_instq.sv
// IFU instruction queue between fetch and decode. Holds entry storage and
// the S-stage output mux; pointer/count bookkeeping lives in the ctl block.
module sparc_ifu_instq
    import sparc_ifu_instq_pkg::*;
#(
    parameter int          DEPTH    = INSTQ_DEPTH_DEF,
    parameter logic [31:0] NOP_INST = INSTQ_NOP_INST
) (
    input  logic                    rclk,
    input  logic                    arst,
    input  logic                    se,
    input  logic                    ifq_inst_vld_f,
    input  logic [31:0]             ifq_inst_f,
    input  logic                    dtu_stall_s,
    input  logic                    fcl_flush_s,
    output logic [31:0]             fdp_dtu_inst_s,
    output logic                    instq_vld_s,
    output logic                    instq_full,
    output logic [$clog2(DEPTH):0]  instq_cnt,
    output logic                    instq_ovf_err
);

    localparam int PW = instq_ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic          w_push;
    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic [CW-1:0] w_cnt;
    logic          w_vld;

    sparc_ifu_instq_ctl #(
        .DEPTH (DEPTH)
    ) u_ctl (
        .rclk           (rclk),
        .arst           (arst),
        .se             (se),
        .ifq_inst_vld_f (ifq_inst_vld_f),
        .dtu_stall_s    (dtu_stall_s),
        .fcl_flush_s    (fcl_flush_s),
        .o_push         (w_push),
        .o_wr_ptr       (w_wr_ptr),
        .o_rd_ptr       (w_rd_ptr),
        .o_cnt          (w_cnt),
        .o_vld          (w_vld),
        .o_full         (instq_full),
        .o_ovf_err      (instq_ovf_err)
    );

    // Entry storage; unreset because the output is masked by the valid bit.
    always_ff @(posedge rclk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= ifq_inst_f;
        end
    end

    // Output mux driven only by registered state, never by the fetch input.
    always_comb begin
        fdp_dtu_inst_s = NOP_INST;
        if (w_vld) begin
            fdp_dtu_inst_s = r_mem[w_rd_ptr];
        end
    end

    assign instq_vld_s = w_vld;
    assign instq_cnt   = w_cnt;

endmodule

// File: tb/tb_sparc_ifu_instq.sv
// Directed bench for the IFU instruction queue at DEPTH=4.
module tb_sparc_ifu_instq;

    localparam logic [31:0] NOP = 32'h0100_0000;

    logic        rclk;
    logic        arst;
    logic        se;
    logic        ifq_inst_vld_f;
    logic [31:0] ifq_inst_f;
    logic        dtu_stall_s;
    logic        fcl_flush_s;
    logic [31:0] fdp_dtu_inst_s;
    logic        instq_vld_s;
    logic        instq_full;
    logic [2:0]  instq_cnt;
    logic        instq_ovf_err;

    int n_tests;
    int n_fail;

    sparc_ifu_instq dut (
        .rclk           (rclk),
        .arst           (arst),
        .se             (se),
        .ifq_inst_vld_f (ifq_inst_vld_f),
        .ifq_inst_f     (ifq_inst_f),
        .dtu_stall_s    (dtu_stall_s),
        .fcl_flush_s    (fcl_flush_s),
        .fdp_dtu_inst_s (fdp_dtu_inst_s),
        .instq_vld_s    (instq_vld_s),
        .instq_full     (instq_full),
        .instq_cnt      (instq_cnt),
        .instq_ovf_err  (instq_ovf_err)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] d, input logic stall, input logic flush);
        ifq_inst_vld_f = vld;
        ifq_inst_f     = d;
        dtu_stall_s    = stall;
        fcl_flush_s    = flush;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        se      = 1'b0;
        arst    = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_cnt",  32'(instq_cnt), 32'd0);
        chk("rst_vld",  32'(instq_vld_s), 32'd0);
        chk("rst_full", 32'(instq_full), 32'd0);
        chk("rst_ovf",  32'(instq_ovf_err), 32'd0);
        chk("rst_inst", fdp_dtu_inst_s, NOP);
        @(negedge rclk);
        arst = 1'b0;
        tick();

        // Fill with decode stalled; first word visible right after its edge.
        drive(1'b1, 32'hAAAA_0001, 1'b1, 1'b0);
        tick();
        chk("lat_vld",  32'(instq_vld_s), 32'd1);
        chk("lat_inst", fdp_dtu_inst_s, 32'hAAAA_0001);
        for (int i = 2; i <= 4; i++) begin
            drive(1'b1, 32'hAAAA_0000 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("fill_full", 32'(instq_full), 32'd1);
        chk("fill_cnt",  32'(instq_cnt), 32'd4);
        chk("fill_inst", fdp_dtu_inst_s, 32'hAAAA_0001);
        tick();
        tick();
        chk("stall_hold", fdp_dtu_inst_s, 32'hAAAA_0001);

        // Drain in order, then nop.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_inst", fdp_dtu_inst_s, 32'hAAAA_0000 + 32'(i));
            tick();
        end
        chk("drain_vld",  32'(instq_vld_s), 32'd0);
        chk("drain_inst", fdp_dtu_inst_s, NOP);
        chk("drain_cnt",  32'(instq_cnt), 32'd0);

        // Overflow: push while full with a simultaneous pop is dropped.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hC000_0000 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 32'hBBBB_0000, 1'b0, 1'b0);
        tick();
        chk("ovf_cnt",  32'(instq_cnt), 32'd3);
        chk("ovf_err",  32'(instq_ovf_err), 32'd1);
        chk("ovf_full", 32'(instq_full), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            chk("ovf_drain", fdp_dtu_inst_s, 32'hC000_0000 + 32'(i));
            tick();
        end
        chk("ovf_drop",   fdp_dtu_inst_s, NOP);
        chk("ovf_sticky", 32'(instq_ovf_err), 32'd1);

        // Flush at count 2 with a push in the same cycle.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hD000_0000 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        chk("pre_flush_cnt", 32'(instq_cnt), 32'd2);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_cnt",  32'(instq_cnt), 32'd0);
        chk("flush_vld",  32'(instq_vld_s), 32'd0);
        chk("flush_inst", fdp_dtu_inst_s, NOP);
        tick();
        chk("flush_nopush", 32'(instq_cnt), 32'd0);

        // Streaming: preload 2, then 10 cycles push+pop across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hE000_0000 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hE000_0000 + 32'(i + 2), 1'b0, 1'b0);
            chk("stream_inst", fdp_dtu_inst_s, 32'hE000_0000 + 32'(i));
            tick();
            chk("stream_cnt", 32'(instq_cnt), 32'd2);
        end
        chk("stream_next", fdp_dtu_inst_s, 32'hE000_000A);
        drive(1'b1, 32'hE000_000C, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre_arst_cnt", 32'(instq_cnt), 32'd3);

        // Asynchronous reset away from any clock edge.
        @(negedge rclk);
        #2;
        arst = 1'b1;
        #1;
        chk("arst_cnt",  32'(instq_cnt), 32'd0);
        chk("arst_vld",  32'(instq_vld_s), 32'd0);
        chk("arst_inst", fdp_dtu_inst_s, NOP);
        chk("arst_ovf",  32'(instq_ovf_err), 32'd0);
        chk("arst_full", 32'(instq_full), 32'd0);
        arst = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_rst_inst", fdp_dtu_inst_s, 32'h1234_5678);
        chk("post_rst_cnt",  32'(instq_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
